// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle control sequencer for a MIPS-subset datapath.
//
// Steps each instruction through IF, ID, EXE, MEM and WB, driving the PC, IR,
// memory, register file and the shared 2-bit-op ALU.
// Supported instructions: addu, subu, slt, ori, addi, addiu, lui, lw, sw,
// beq and j.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   instr      in   memory read data; opcode/funct latched on ir_wr
//   mem_rdy    in   memory access completes this cycle
//   zero       in   ALU zero flag (beq)
//   overflow   in   ALU signed overflow (addi)
//   pc_wr      out  PC load strobe
//   pc_src     out  00 pc+4, 01 branch target, 10 jump target
//   ir_wr      out  IR load strobe
//   iord       out  memory address: 0 PC, 1 ALU result
//   mem_rd     out  memory read strobe
//   mem_wr     out  memory write strobe
//   alu_op     out  00 add, 01 sub, 10 or, 11 slt
//   alu_srcb   out  ALU B: 0 busb, 1 extended immediate
//   ext_op     out  00 zero-extend, 01 sign-extend, 10 imm<<16
//   reg_wr     out  register write strobe
//   reg_dst    out  destination: 0 rt, 1 rd
//   mem_to_reg out  write data: 0 ALU, 1 memory
//   ovf_trap   out  one-cycle pulse when addi overflows
//   illegal    out  one-cycle pulse on an unsupported encoding
//   state      out  current state (debug)
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_rdy,
    input  logic        zero,
    input  logic        overflow,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        ir_wr,
    output logic        iord,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  alu_op,
    output logic        alu_srcb,
    output logic [1:0]  ext_op,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        ovf_trap,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       ovf_q, ovf_d;
    // Set on the first clock edge after reset release; until then the
    // controller sits in IF with every strobe held low, so a mem_rdy
    // seen in the release cycle cannot start a fetch.
    logic       armed_q;

    // Only opcode and funct are decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    // Decode of the latched opcode/funct.
    logic is_rtype, is_addu, is_subu, is_slt;
    logic is_ori, is_addi, is_addiu, is_lui, is_lw, is_sw, is_beq, is_j;
    logic is_legal;

    assign is_rtype = (op_q == 6'b000000);
    assign is_addu  = is_rtype && (funct_q == 6'b100001);
    assign is_subu  = is_rtype && (funct_q == 6'b100011);
    assign is_slt   = is_rtype && (funct_q == 6'b101010);
    assign is_ori   = (op_q == 6'b001101);
    assign is_addi  = (op_q == 6'b001000);
    assign is_addiu = (op_q == 6'b001001);
    assign is_lui   = (op_q == 6'b001111);
    assign is_lw    = (op_q == 6'b100011);
    assign is_sw    = (op_q == 6'b101011);
    assign is_beq   = (op_q == 6'b000100);
    assign is_j     = (op_q == 6'b000010);
    assign is_legal = is_addu | is_subu | is_slt | is_ori | is_addi | is_addiu |
                      is_lui | is_lw | is_sw | is_beq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            op_q    <= '0;
            funct_q <= '0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            ovf_q   <= ovf_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        funct_d    = funct_q;
        ovf_d      = ovf_q;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        ir_wr      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_op     = 2'b00;
        alu_srcb   = 1'b0;
        ext_op     = 2'b00;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ovf_trap   = 1'b0;
        illegal    = 1'b0;

        if (armed_q) begin
            // ALU controls are set in EXE and held through MEM/WB so the
            // ALU result (address or write-back value) stays stable.
            if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
                if (is_subu || is_beq) begin
                    alu_op = 2'b01;
                end else if (is_slt) begin
                    alu_op = 2'b11;
                end else if (is_ori) begin
                    alu_op   = 2'b10;
                    alu_srcb = 1'b1;
                    ext_op   = 2'b00;
                end else if (is_addi || is_addiu || is_lw || is_sw) begin
                    alu_srcb = 1'b1;
                    ext_op   = 2'b01;
                end else if (is_lui) begin
                    alu_srcb = 1'b1;
                    ext_op   = 2'b10;
                end
            end

            case (state_q)
                S_IF: begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        ir_wr   = 1'b1;
                        pc_wr   = 1'b1;
                        op_d    = instr[31:26];
                        funct_d = instr[5:0];
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    if (is_j) begin
                        pc_wr   = 1'b1;
                        pc_src  = 2'b10;
                        state_d = S_IF;
                    end else if (!is_legal) begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: begin
                    ovf_d = is_addi & overflow;
                    if (is_beq) begin
                        pc_wr   = zero;
                        pc_src  = 2'b01;
                        state_d = S_IF;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    iord   = 1'b1;
                    mem_rd = is_lw;
                    mem_wr = is_sw;
                    if (mem_rdy) begin
                        state_d = is_lw ? S_WB : S_IF;
                    end
                end
                S_WB: begin
                    reg_wr     = !(is_addi && ovf_q);
                    ovf_trap   = is_addi && ovf_q;
                    reg_dst    = is_rtype;
                    mem_to_reg = is_lw;
                    state_d    = S_IF;
                end
                default: begin
                    state_d = S_IF;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. Each step drives inputs shortly after a rising
// edge, pushes the expected output vector onto a scoreboard queue, then pops
// and compares it against the DUT mid-cycle.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_rdy, zero, overflow;
    logic        pc_wr, ir_wr, iord, mem_rd, mem_wr, alu_srcb;
    logic        reg_wr, reg_dst, mem_to_reg, ovf_trap, illegal;
    logic [1:0]  pc_src, alu_op, ext_op;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] alu_op;
        logic       alu_srcb;
        logic [1:0] ext_op;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ovf_trap;
        logic       illegal;
    } outs_t;

    outs_t sb_q[$];
    outs_t e;
    int    tests = 0;
    int    fails = 0;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .mem_rdy    (mem_rdy),
        .zero       (zero),
        .overflow   (overflow),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .ir_wr      (ir_wr),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .alu_op     (alu_op),
        .alu_srcb   (alu_srcb),
        .ext_op     (ext_op),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ovf_trap   (ovf_trap),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic outs_t observe();
        outs_t o;
        o.st         = state;
        o.pc_wr      = pc_wr;
        o.pc_src     = pc_src;
        o.ir_wr      = ir_wr;
        o.iord       = iord;
        o.mem_rd     = mem_rd;
        o.mem_wr     = mem_wr;
        o.alu_op     = alu_op;
        o.alu_srcb   = alu_srcb;
        o.ext_op     = ext_op;
        o.reg_wr     = reg_wr;
        o.reg_dst    = reg_dst;
        o.mem_to_reg = mem_to_reg;
        o.ovf_trap   = ovf_trap;
        o.illegal    = illegal;
        return o;
    endfunction

    // Sample mid-cycle (well away from both edges), then advance one cycle.
    task automatic chk(input string tag, input bit advance);
        outs_t obs, exp;
        sb_q.push_back(e);
        #3;
        obs = observe();
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            tests++;
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp);
            end
        end
        if (advance) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic step(input string tag);
        chk(tag, 1'b1);
    endtask

    // IF cycle with memory ready: fetch strobes only.
    task automatic fetch(input logic [31:0] iw, input string tag);
        instr = iw; mem_rdy = 1'b1;
        e = '0; e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        step(tag);
        instr = 32'hFFFF_FFFF; mem_rdy = 1'b1;   // ID ignores both
        e = '0; e.st = 3'd1;
    endtask

    task automatic exe_imm(input logic [1:0] aop, input logic [1:0] ext);
        e = '0; e.st = 3'd2; e.alu_op = aop; e.alu_srcb = 1'b1; e.ext_op = ext;
    endtask

    initial begin
        rst = 1'b0; instr = '0; mem_rdy = 1'b1; zero = 1'b0; overflow = 1'b0;
        @(posedge clk); #2;

        // Reset: everything low even with mem_rdy asserted.
        e = '0; step("reset");
        // Release mid-cycle with mem_rdy high: no fetch strobe this cycle.
        rst = 1'b1; instr = 32'h0022_1821; e = '0; step("release_cycle");

        // addu
        fetch(32'h0022_1821, "addu IF");
        mem_rdy = 1'b0; step("addu ID");
        e = '0; e.st = 3'd2; step("addu EXE");
        e = '0; e.st = 3'd4; e.reg_wr = 1'b1; e.reg_dst = 1'b1; step("addu WB");

        // subu / slt EXE encodings
        fetch(32'h0022_1823, "subu IF"); step("subu ID");
        e = '0; e.st = 3'd2; e.alu_op = 2'b01; step("subu EXE");
        e.st = 3'd4; e.reg_wr = 1'b1; e.reg_dst = 1'b1; step("subu WB");
        fetch(32'h0022_182A, "slt IF"); step("slt ID");
        e = '0; e.st = 3'd2; e.alu_op = 2'b11; step("slt EXE");
        e.st = 3'd4; e.reg_wr = 1'b1; e.reg_dst = 1'b1; step("slt WB");

        // lw with two wait states in MEM
        fetch(32'h8C22_0004, "lw IF"); step("lw ID");
        exe_imm(2'b00, 2'b01); step("lw EXE");
        mem_rdy = 1'b0;
        e.st = 3'd3; e.iord = 1'b1; e.mem_rd = 1'b1; step("lw MEM wait1");
        step("lw MEM wait2");
        mem_rdy = 1'b1; step("lw MEM ready");
        mem_rdy = 1'b0;
        e.st = 3'd4; e.iord = 1'b0; e.mem_rd = 1'b0;
        e.reg_wr = 1'b1; e.mem_to_reg = 1'b1; step("lw WB");
        e = '0; e.mem_rd = 1'b1; step("lw back IF stall");

        // beq taken / not taken
        fetch(32'h1022_0003, "beq1 IF"); step("beq1 ID");
        zero = 1'b1;
        e = '0; e.st = 3'd2; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_wr = 1'b1;
        step("beq taken EXE");
        zero = 1'b0;
        fetch(32'h1022_0003, "beq2 IF"); step("beq2 ID");
        e = '0; e.st = 3'd2; e.alu_op = 2'b01; e.pc_src = 2'b01;
        step("beq not taken EXE");

        // addi overflow trap, addi clean, addiu never traps
        fetch(32'h2022_0001, "addi ovf IF"); step("addi ovf ID");
        overflow = 1'b1; exe_imm(2'b00, 2'b01); step("addi ovf EXE");
        overflow = 1'b0; e.st = 3'd4; e.ovf_trap = 1'b1; step("addi ovf WB");
        fetch(32'h2022_0001, "addi IF"); step("addi ID");
        exe_imm(2'b00, 2'b01); step("addi EXE");
        overflow = 1'b1; e.st = 3'd4; e.reg_wr = 1'b1; step("addi WB");
        fetch(32'h2422_0001, "addiu IF"); step("addiu ID");
        exe_imm(2'b00, 2'b01); step("addiu EXE");
        e.st = 3'd4; e.reg_wr = 1'b1; step("addiu WB");
        overflow = 1'b0;

        // ori and lui
        fetch(32'h3422_0005, "ori IF"); step("ori ID");
        exe_imm(2'b10, 2'b00); step("ori EXE");
        e.st = 3'd4; e.reg_wr = 1'b1; step("ori WB");
        fetch(32'h3C01_ABCD, "lui IF"); step("lui ID");
        exe_imm(2'b00, 2'b10); step("lui EXE");
        e.st = 3'd4; e.reg_wr = 1'b1; step("lui WB");

        // j, illegal opcode, illegal R-type funct
        fetch(32'h0800_0010, "j IF");
        e.pc_wr = 1'b1; e.pc_src = 2'b10; step("j ID");
        fetch(32'hFC00_0000, "ill op IF");
        e.illegal = 1'b1; step("ill op ID");
        fetch(32'h0000_0000, "ill funct IF");
        e.illegal = 1'b1; step("ill funct ID");

        // sw, reset dropped while held in MEM
        fetch(32'hAC22_0004, "sw IF"); step("sw ID");
        exe_imm(2'b00, 2'b01); step("sw EXE");
        mem_rdy = 1'b0;
        e.st = 3'd3; e.iord = 1'b1; e.mem_wr = 1'b1; step("sw MEM wait");
        e.st = 3'd3; chk("sw MEM before rst", 1'b0);
        rst = 1'b0; #1;
        e = '0; chk("sw rst drop", 1'b0);
        @(posedge clk); #2;
        mem_rdy = 1'b1; rst = 1'b1; e = '0; step("rst release2");
        fetch(32'h0022_1821, "refetch IF");
        mem_rdy = 1'b0; step("refetch ID");

        if (sb_q.size() != 0) begin
            fails++;
            $error("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
